// File: rtl/cpu_step_controller.sv
// Debugger step sequencer: gates the CPU clock enable for one bus cycle, one
// instruction, up to a breakpoint, or until halted, then pulses completion.
module cpu_step_controller #(
    parameter int COUNT_WIDTH    = 24,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic                   i_start_step,
    input  logic [1:0]             i_mode,
    input  logic                   i_bp_enable,
    input  logic [15:0]            i_bp_address,
    input  logic                   i_halt,
    input  logic                   i_cpu_sync,
    input  logic [15:0]            i_cpu_address,
    output logic                   o_cpu_clk_en,
    output logic                   o_step_completed,
    output logic                   o_busy,
    output logic [2:0]             o_stop_reason,
    output logic [COUNT_WIDTH-1:0] o_cycle_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] TIMEOUT_LIMIT = COUNT_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX     = {COUNT_WIDTH{1'b1}};

    state_t                   state_reg;
    logic [1:0]               mode_reg;
    logic                     start_prev_reg;
    logic                     start_armed_reg;
    logic [COUNT_WIDTH-1:0]   count_reg;
    logic [2:0]               reason_reg;
    logic                     completed_reg;
    logic                     busy_reg;

    logic                     started_once;
    logic                     at_boundary;
    logic                     mode_hit;
    logic [2:0]               mode_reason;
    logic                     timeout_hit;
    logic                     stop_cond;
    logic [2:0]               stop_reason;
    logic                     start_detect;

    // A start needs the request to have been seen low since reset, so a
    // request still held high across a reset cannot launch a step.
    assign start_detect = i_start_step && !start_prev_reg && start_armed_reg;

    always_comb begin
        started_once = (count_reg != '0);
        at_boundary  = started_once && i_cpu_sync;
        mode_hit     = 1'b0;
        mode_reason  = 3'd0;
        case (mode_reg)
            2'd0: begin
                mode_hit    = started_once;
                mode_reason = 3'd1;
            end
            2'd1: begin
                mode_hit    = at_boundary;
                mode_reason = 3'd2;
            end
            2'd2: begin
                mode_hit    = at_boundary && i_bp_enable && (i_cpu_address == i_bp_address);
                mode_reason = 3'd3;
            end
            2'd3: begin
                mode_hit    = at_boundary && i_halt;
                mode_reason = 3'd4;
            end
        endcase
        timeout_hit = ((mode_reg == 2'd1) || (mode_reg == 2'd2)) && (count_reg >= TIMEOUT_LIMIT);
        stop_cond   = mode_hit || timeout_hit;
        stop_reason = mode_hit ? mode_reason : 3'd5;
    end

    // Combinational so that the stopping clock never advances the CPU and an
    // asynchronous reset removes the enable immediately.
    assign o_cpu_clk_en     = (state_reg == RUN) && !stop_cond;
    assign o_step_completed = completed_reg;
    assign o_busy           = busy_reg;
    assign o_stop_reason    = reason_reg;
    assign o_cycle_count    = count_reg;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg       <= IDLE;
            mode_reg        <= 2'd0;
            start_prev_reg  <= 1'b0;
            start_armed_reg <= 1'b0;
            count_reg       <= '0;
            reason_reg      <= 3'd0;
            completed_reg   <= 1'b0;
            busy_reg        <= 1'b0;
        end else begin
            start_prev_reg <= i_start_step;
            if (!i_start_step) begin
                start_armed_reg <= 1'b1;
            end
            completed_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start_detect) begin
                        mode_reg   <= i_mode;
                        count_reg  <= '0;
                        reason_reg <= 3'd0;
                        busy_reg   <= 1'b1;
                        state_reg  <= RUN;
                    end
                end
                RUN: begin
                    if (stop_cond) begin
                        reason_reg    <= stop_reason;
                        completed_reg <= 1'b1;
                        state_reg     <= DONE;
                    end else if (count_reg != COUNT_MAX) begin
                        count_reg <= count_reg + 1'b1;
                    end
                end
                DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_step_controller.sv
// Bench for cpu_step_controller: a toy CPU with variable-length instructions,
// a per-cycle step model compared every negedge, and directed step scenarios.
module tb_cpu_step_controller;

    localparam int CW      = 24;
    localparam int TIMEOUT = 16;

    logic          clk;
    logic          rst_n;
    logic          start_step;
    logic [1:0]    mode;
    logic          bp_enable;
    logic [15:0]   bp_address;
    logic          halt;
    logic          cpu_sync;
    logic [15:0]   cpu_address;
    logic          clk_en;
    logic          step_completed;
    logic          busy;
    logic [2:0]    stop_reason;
    logic [CW-1:0] cycle_count;

    int checks = 0;
    int fails  = 0;
    int en_cnt = 0;
    int pulse_cnt = 0;

    cpu_step_controller #(
        .COUNT_WIDTH    (CW),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .i_clk            (clk),
        .i_reset_n        (rst_n),
        .i_start_step     (start_step),
        .i_mode           (mode),
        .i_bp_enable      (bp_enable),
        .i_bp_address     (bp_address),
        .i_halt           (halt),
        .i_cpu_sync       (cpu_sync),
        .i_cpu_address    (cpu_address),
        .o_cpu_clk_en     (clk_en),
        .o_step_completed (step_completed),
        .o_busy           (busy),
        .o_stop_reason    (stop_reason),
        .o_cycle_count    (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Toy CPU: an instruction of length L occupies L bus cycles at pc..pc+L-1,
    // with sync on the first (opcode fetch) cycle.
    logic [15:0] cpu_pc;
    int          cpu_phase;
    logic        load_req;
    logic [15:0] load_pc;

    function automatic int instr_len(input logic [15:0] pc);
        case (pc)
            16'h8000: return 2;
            16'h8002: return 3;
            16'h8005: return 2;
            default:  return 3;
        endcase
    endfunction

    assign cpu_sync    = (cpu_phase == 0);
    assign cpu_address = cpu_pc + 16'(cpu_phase);

    always @(posedge clk) begin
        if (load_req) begin
            cpu_pc    <= load_pc;
            cpu_phase <= 0;
        end else if (clk_en) begin
            if (cpu_phase + 1 == instr_len(cpu_pc)) begin
                cpu_pc    <= cpu_pc + 16'(instr_len(cpu_pc));
                cpu_phase <= 0;
            end else begin
                cpu_phase <= cpu_phase + 1;
            end
        end
    end

    // Step model: one step = a run of enabled cycles ended by the first cycle
    // on which a stop rule fires, followed by one completion cycle.
    bit m_run, m_done, m_prev, m_armed;
    int m_mode, m_count, m_reason, r;
    bit exp_en;
    localparam int CMAX = (1 << CW) - 1;

    always @(negedge clk) begin
        if (clk_en) en_cnt++;
        if (step_completed) pulse_cnt++;
        if (!rst_n) begin
            m_run = 0; m_done = 0; m_prev = 0; m_armed = 0;
            m_mode = 0; m_count = 0; m_reason = 0;
            check("rst_clk_en", clk_en, 0);
            check("rst_completed", step_completed, 0);
            check("rst_busy", busy, 0);
            check("rst_reason", stop_reason, 0);
            check("rst_count", cycle_count, 0);
        end else begin
            r = 0;
            if (m_run) begin
                if (m_mode == 0 && m_count >= 1) r = 1;
                if (m_mode == 1 && m_count >= 1 && cpu_sync) r = 2;
                if (m_mode == 2 && m_count >= 1 && cpu_sync && bp_enable && cpu_address == bp_address) r = 3;
                if (m_mode == 3 && m_count >= 1 && cpu_sync && halt) r = 4;
                if (r == 0 && (m_mode == 1 || m_mode == 2) && m_count >= TIMEOUT) r = 5;
            end
            exp_en = m_run && (r == 0);
            check("clk_en", clk_en, exp_en);
            check("completed", step_completed, m_done);
            check("busy", busy, m_run || m_done);
            check("reason", stop_reason, m_reason);
            check("count", cycle_count, m_count);
            if (m_done) begin
                m_done = 0;
            end else if (m_run) begin
                if (r != 0) begin
                    m_run = 0; m_done = 1; m_reason = r;
                end else if (m_count < CMAX) begin
                    m_count++;
                end
            end else if (start_step && !m_prev && m_armed) begin
                m_run = 1; m_mode = int'(mode); m_count = 0; m_reason = 0;
            end
            m_prev = start_step;
            if (!start_step) m_armed = 1;
        end
    end

    task automatic load_cpu(input logic [15:0] pc);
        @(posedge clk); #1 load_pc = pc; load_req = 1'b1;
        @(posedge clk); #1 load_req = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!step_completed && k < 200);
        check({tag, "_done_seen"}, step_completed, 1);
    endtask

    task automatic run_step(input logic [1:0] md, input int exp_count, input int exp_reason,
                            input int exp_lat, input string tag);
        int en0, p0, k;
        en0 = en_cnt;
        p0  = pulse_cnt;
        @(posedge clk); #1 start_step = 1'b0;
        @(posedge clk); #1 mode = md; start_step = 1'b1;
        wait_done(tag, k);
        if (exp_lat > 0) check({tag, "_latency"}, k, exp_lat);
        @(posedge clk); #1 start_step = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check({tag, "_enabled"}, en_cnt - en0, exp_count);
        check({tag, "_pulses"}, pulse_cnt - p0, 1);
        check({tag, "_count"}, cycle_count, exp_count);
        check({tag, "_reason"}, stop_reason, exp_reason);
        $display("step %s: mode=%0d count=%0d reason=%0d", tag, md, cycle_count, stop_reason);
    endtask

    initial begin
        int en0, p0, k;
        rst_n = 1'b0; start_step = 1'b0; mode = 2'd0;
        bp_enable = 1'b0; bp_address = 16'h0000; halt = 1'b0;
        load_req = 1'b1; load_pc = 16'h1000;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_count", cycle_count, 0);
        rst_n = 1'b1; load_req = 1'b0;

        // Single bus cycle
        load_cpu(16'h1000);
        run_step(2'd0, 1, 1, 4, "cycle");

        // One 3-cycle instruction, stops with next fetch pending
        load_cpu(16'h1000);
        run_step(2'd1, 3, 2, 0, "instr");
        check("instr_sync_pending", cpu_sync, 1);
        check("instr_next_pc", cpu_address, 16'h1003);

        // Breakpoint at 0x8005
        bp_enable = 1'b1; bp_address = 16'h8005;
        load_cpu(16'h8000);
        run_step(2'd2, 5, 3, 0, "bp_hit");
        check("bp_pending_addr", cpu_address, 16'h8005);
        // Step off the breakpoint: it must not re-trigger at once
        run_step(2'd2, 16, 5, 0, "bp_leave");

        // Breakpoint disabled: timeout
        bp_enable = 1'b0;
        load_cpu(16'h1000);
        run_step(2'd2, 16, 5, 0, "bp_off");

        // Free run, halt mid-instruction, extra start edge while busy
        load_cpu(16'h1000);
        en0 = en_cnt; p0 = pulse_cnt;
        @(posedge clk); #1 mode = 2'd3; start_step = 1'b1;
        repeat (2) @(posedge clk);
        #1 start_step = 1'b0;
        @(posedge clk); #1 start_step = 1'b1;
        repeat (2) @(posedge clk);
        #1 halt = 1'b1;
        wait_done("halt", k);
        @(posedge clk); #1 start_step = 1'b0; halt = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("halt_enabled", en_cnt - en0, 6);
        check("halt_pulses", pulse_cnt - p0, 1);
        check("halt_count", cycle_count, 6);
        check("halt_reason", stop_reason, 4);
        $display("step halt: mode=3 count=%0d reason=%0d", cycle_count, stop_reason);

        // Reset in the middle of a free run
        load_cpu(16'h2000);
        p0 = pulse_cnt;
        @(posedge clk); #1 mode = 2'd3; start_step = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("pre_reset_clk_en", clk_en, 1);
        rst_n = 1'b0;
        #1;
        check("async_clk_en", clk_en, 0);
        check("async_busy", busy, 0);
        check("async_count", cycle_count, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("held_start_busy", busy, 0);
        check("reset_no_pulse", pulse_cnt - p0, 0);
        $display("reset mid-run: busy=%0d pulses=%0d", busy, pulse_cnt - p0);
        halt = 1'b1;
        run_step(2'd3, 1, 4, 0, "after_reset");
        halt = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
